// File: rtl/alu_issue_seq_pkg.sv
// Shared constants, instruction field positions and FSM state type for the
// ALU issue/writeback sequencer.
package alu_issue_seq_pkg;

  localparam logic [3:0] OP_ADD  = 4'h8;
  localparam logic [3:0] OP_ADDI = 4'h9;

  localparam logic TYPE_R = 1'b0;
  localparam logic TYPE_I = 1'b1;

  localparam int OP_HI    = 15;
  localparam int OP_LO    = 12;
  localparam int TYPE_BIT = 11;
  localparam int RD_HI    = 10;
  localparam int RD_LO    = 8;
  localparam int RS_HI    = 7;
  localparam int RS_LO    = 5;
  localparam int RM_HI    = 4;
  localparam int RM_LO    = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_IMM  = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_e;

endpackage

// File: rtl/alu_issue_seq_regfile.sv
// 8x16 register file: three operand read ports, a debug read port, one write port.
// ALU_ISSUE_SEQ_R0_ZERO_EN makes register 0 read as zero on every read port.
module alu_regfile #(
  parameter int NREGS = 8,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [2:0]    waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [2:0]    rd_addr_i,
  input  logic [2:0]    rs_addr_i,
  input  logic [2:0]    rm_addr_i,
  input  logic [2:0]    dbg_addr_i,
  output logic [DW-1:0] rd_data_o,
  output logic [DW-1:0] rs_data_o,
  output logic [DW-1:0] rm_data_o,
  output logic [DW-1:0] dbg_data_o
);

`ifdef ALU_ISSUE_SEQ_R0_ZERO_EN
  localparam bit R0_ZERO = 1'b1;
`else
  localparam bit R0_ZERO = 1'b0;
`endif

  logic [DW-1:0] mem_q [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rd_data_o  = (R0_ZERO && rd_addr_i  == 3'd0) ? '0 : mem_q[rd_addr_i];
  assign rs_data_o  = (R0_ZERO && rs_addr_i  == 3'd0) ? '0 : mem_q[rs_addr_i];
  assign rm_data_o  = (R0_ZERO && rm_addr_i  == 3'd0) ? '0 : mem_q[rm_addr_i];
  assign dbg_data_o = (R0_ZERO && dbg_addr_i == 3'd0) ? '0 : mem_q[dbg_addr_i];

endmodule

// File: rtl/alu_issue_seq.sv
// Issue/writeback sequencer in front of the combinational 16-bit ALU.
// ALU_ISSUE_SEQ_R0_ZERO_EN: R0 reads zero and writes to R0 are dropped.
module alu_issue_seq
  import alu_issue_seq_pkg::*;
#(
  parameter int NREGS = 8,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic [DW-1:0] alu_instruction,
  output logic [DW-1:0] alu_rddata,
  output logic [DW-1:0] alu_rsdata,
  output logic [DW-1:0] alu_rmdata,
  output logic [DW-1:0] alu_n,
  input  logic [DW-1:0] alu_result,
  output logic          wb_valid,
  output logic [2:0]    wb_addr,
  output logic [DW-1:0] wb_data,
  output logic          bad_op,
  input  logic [2:0]    dbg_addr,
  output logic [DW-1:0] dbg_data
);

`ifdef ALU_ISSUE_SEQ_R0_ZERO_EN
  localparam bit R0_ZERO = 1'b1;
`else
  localparam bit R0_ZERO = 1'b0;
`endif

  state_e        state_q, state_d;
  logic [DW-1:0] instr_q, instr_d;
  logic [DW-1:0] n_q, n_d;
  logic [DW-1:0] result_q, result_d;
  logic [2:0]    wb_addr_q, wb_addr_d;
  logic [DW-1:0] wb_data_q, wb_data_d;
  logic          rdy_q;
  logic          rf_we;

  logic [3:0] opcode;
  logic [2:0] rd_idx, rs_idx, rm_idx;
  logic       supported;
  logic       commit;

  assign opcode    = instr_q[OP_HI:OP_LO];
  assign rd_idx    = instr_q[RD_HI:RD_LO];
  assign rs_idx    = instr_q[RS_HI:RS_LO];
  assign rm_idx    = instr_q[RM_HI:RM_LO];
  assign supported = (opcode == OP_ADD) || (opcode == OP_ADDI);
  assign commit    = supported && !(R0_ZERO && rd_idx == 3'd0);

  // rdy_q keeps in_ready low during reset and for the release cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      instr_q   <= '0;
      n_q       <= '0;
      result_q  <= '0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      rdy_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      n_q       <= n_d;
      result_q  <= result_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
      rdy_q     <= 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    n_d       = n_q;
    result_d  = result_q;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    in_ready  = 1'b0;
    wb_valid  = 1'b0;
    bad_op    = 1'b0;
    rf_we     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = rdy_q;
        if (in_valid && rdy_q) begin
          instr_d = in_data;
          n_d     = '0;
          state_d = (in_data[TYPE_BIT] == TYPE_I) ? ST_IMM : ST_EXEC;
        end
      end
      ST_IMM: begin
        in_ready = rdy_q;
        if (in_valid && rdy_q) begin
          n_d     = in_data;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        result_d = alu_result;
        // Load the writeback outputs only for a real write so they hold otherwise.
        if (commit) begin
          wb_addr_d = rd_idx;
          wb_data_d = alu_result;
        end
        state_d = ST_WB;
      end
      ST_WB: begin
        rf_we    = commit;
        wb_valid = commit;
        bad_op   = !supported;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  alu_regfile #(
    .NREGS (NREGS),
    .DW    (DW)
  ) u_regfile (
    .clk        (clk),
    .rst_n      (reset_n),
    .we_i       (rf_we),
    .waddr_i    (rd_idx),
    .wdata_i    (result_q),
    .rd_addr_i  (rd_idx),
    .rs_addr_i  (rs_idx),
    .rm_addr_i  (rm_idx),
    .dbg_addr_i (dbg_addr),
    .rd_data_o  (alu_rddata),
    .rs_data_o  (alu_rsdata),
    .rm_data_o  (alu_rmdata),
    .dbg_data_o (dbg_data)
  );

  assign alu_instruction = instr_q;
  assign alu_n           = n_q;
  assign wb_addr         = wb_addr_q;
  assign wb_data         = wb_data_q;

endmodule
